// File: rtl/lfsr_stream_encryptor.sv
// Pads a 41-byte plaintext stream into a 64-byte frame and XORs each byte with a running 8-bit LFSR.
// Latency: 1 cycle from input accept to out_valid; stalls hold the output register and freeze the LFSR.
module lfsr_stream_encryptor #(
  parameter int          MSG_LEN   = 41,
  parameter int          FRAME_LEN = 64,
  parameter logic [7:0]  PAD_CHAR  = 8'h20
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] cfg_pre_len,
  input  logic [7:0] cfg_taps,
  input  logic [7:0] cfg_seed,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_index,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_MSG,
    S_POST,
    S_DONE
  } state_t;

  localparam logic [5:0] MAX_PRE  = 6'(FRAME_LEN - MSG_LEN);
  localparam logic [5:0] LAST_POS = 6'(FRAME_LEN - 1);
  localparam logic [5:0] LAST_MSG = 6'(MSG_LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] taps_q, taps_d;
  logic [5:0] pre_len_q, pre_len_d;
  logic [5:0] pos_q, pos_d;
  logic [5:0] msg_cnt_q, msg_cnt_d;
  logic [7:0] out_dat_q, out_dat_d;
  logic [5:0] out_idx_q, out_idx_d;
  logic       out_vld_q, out_vld_d;
  logic       err_q, err_d;

  logic       slot_free;
  logic       load;
  logic [7:0] src;
  logic       in_rdy;

  // The output register can take a new byte when empty or being drained this cycle.
  assign slot_free = !out_vld_q || out_ready;

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    taps_d    = taps_q;
    pre_len_d = pre_len_q;
    pos_d     = pos_q;
    msg_cnt_d = msg_cnt_q;
    out_dat_d = out_dat_q;
    out_idx_d = out_idx_q;
    out_vld_d = out_vld_q && !out_ready;
    err_d     = err_q;
    load      = 1'b0;
    src       = PAD_CHAR;
    in_rdy    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          taps_d    = cfg_taps;
          pre_len_d = cfg_pre_len;
          lfsr_d    = cfg_seed;
          pos_d     = 6'd0;
          msg_cnt_d = 6'd0;
          err_d     = 1'b0;
          if (cfg_pre_len > MAX_PRE) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else if (cfg_pre_len == 6'd0) begin
            state_d = S_MSG;
          end else begin
            state_d = S_PRE;
          end
        end
      end
      S_PRE: begin
        if (slot_free) begin
          load = 1'b1;
          if (pos_q == 6'(pre_len_q - 6'd1)) state_d = S_MSG;
        end
      end
      S_MSG: begin
        in_rdy = slot_free;
        if (in_valid && slot_free) begin
          load      = 1'b1;
          src       = in_data;
          msg_cnt_d = msg_cnt_q + 6'd1;
          if (msg_cnt_q == LAST_MSG) begin
            // A maximal preamble leaves no room for postamble padding.
            state_d = (pos_q == LAST_POS) ? S_DONE : S_POST;
          end
        end
      end
      S_POST: begin
        if (slot_free) begin
          load = 1'b1;
          if (pos_q == LAST_POS) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      out_dat_d = src ^ lfsr_q;
      out_idx_d = pos_q;
      out_vld_d = 1'b1;
      lfsr_d    = {lfsr_q[6:0], ^(lfsr_q & taps_q)};
      pos_d     = pos_q + 6'd1;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      lfsr_q    <= 8'd0;
      taps_q    <= 8'd0;
      pre_len_q <= 6'd0;
      pos_q     <= 6'd0;
      msg_cnt_q <= 6'd0;
      out_dat_q <= 8'd0;
      out_idx_q <= 6'd0;
      out_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      taps_q    <= taps_d;
      pre_len_q <= pre_len_d;
      pos_q     <= pos_d;
      msg_cnt_q <= msg_cnt_d;
      out_dat_q <= out_dat_d;
      out_idx_q <= out_idx_d;
      out_vld_q <= out_vld_d;
      err_q     <= err_d;
    end
  end

  assign in_ready  = in_rdy;
  assign out_data  = out_dat_q;
  assign out_index = out_idx_q;
  assign out_valid = out_vld_q;
  assign busy      = (state_q == S_PRE) || (state_q == S_MSG) || (state_q == S_POST);
  // done stays masked until the final byte has left the output register.
  assign done      = (state_q == S_DONE) && !out_vld_q;
  assign err       = err_q;

endmodule
